// File: rtl/mem_access_ctrl.sv
// Memory access sequencer between the LC-3 datapath and its 16-bit registered-output RAM.
// Optional MEM_WAIT_STATE_EN stretches every strobe phase by WAIT_CYCLES extra cycles.
module mem_access_ctrl #(
    parameter int WORD_SIZE    = 16,
    parameter int ADDRESS_SIZE = 16,
    parameter int WAIT_CYCLES  = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic                    req_indirect,
    input  logic [ADDRESS_SIZE-1:0] req_address,
    input  logic [WORD_SIZE-1:0]    req_data,
    output logic                    rsp_valid,
    output logic [WORD_SIZE-1:0]    rsp_data,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0]    mem_in_data,
    input  logic [WORD_SIZE-1:0]    mem_out_data,
    output logic [2:0]              dbg_state
);

    // Handshake: a request is taken at a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and requests seen while busy are dropped.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PTR_RD   = 3'd1,
        PTR_CAP  = 3'd2,
        DATA_RD  = 3'd3,
        DATA_CAP = 3'd4,
        DATA_WR  = 3'd5
    } state_t;

    if ((ADDRESS_SIZE > WORD_SIZE) || (WAIT_CYCLES < 0)) begin : g_bad_params
        $error("mem_access_ctrl: ADDRESS_SIZE must be <= WORD_SIZE and WAIT_CYCLES >= 0");
    end

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_phase_done;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0]    r_data;
    logic                    r_write;
    logic                    r_rsp_valid;
    logic [WORD_SIZE-1:0]    r_rsp_data;

`ifdef MEM_WAIT_STATE_EN
    localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [WCW-1:0] r_wait_cnt;

    // Reloaded on every state change, so each strobe phase starts with a full count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_wait_cnt <= WCW'(WAIT_CYCLES);
        end else if (r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - WCW'(1);
        end
    end

    assign w_phase_done = (r_wait_cnt == '0);
`else
    assign w_phase_done = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (req_indirect) begin
                        w_next_state = PTR_RD;
                    end else if (req_write) begin
                        w_next_state = DATA_WR;
                    end else begin
                        w_next_state = DATA_RD;
                    end
                end
            end
            PTR_RD:   if (w_phase_done) w_next_state = PTR_CAP;
            PTR_CAP:  w_next_state = r_write ? DATA_WR : DATA_RD;
            DATA_RD:  if (w_phase_done) w_next_state = DATA_CAP;
            DATA_CAP: w_next_state = IDLE;
            DATA_WR:  if (w_phase_done) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_data      <= '0;
            r_write     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_address;
                        r_data  <= req_data;
                        r_write <= req_write;
                    end
                end
                // Pointer words wider than the address bus lose their upper bits.
                PTR_CAP: r_addr <= mem_out_data[ADDRESS_SIZE-1:0];
                DATA_CAP: begin
                    r_rsp_data  <= mem_out_data;
                    r_rsp_valid <= 1'b1;
                end
                DATA_WR: begin
                    if (w_phase_done) begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign mem_read    = (r_state == PTR_RD) || (r_state == DATA_RD);
    assign mem_write   = (r_state == DATA_WR);
    assign mem_address = r_addr;
    assign mem_in_data = r_data;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign dbg_state   = r_state;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory access sequencer sitting directly upstream of the 16-bit LC-3 RAM; converts single CPU load/store requests into RAM read/write strobes.
- Supports direct accesses (LD/ST/LDR/STR/instruction fetch) and indirect accesses (LDI/STI): pointer fetch, then data access.
- Drives the RAM's read, write, address and in_data pins; captures its registered out_data.
- Returns results to the CPU datapath over a valid/ready request channel and a one-cycle response pulse.

Parameters:
- WORD_SIZE, 16, data and pointer width.
- ADDRESS_SIZE, 16, RAM address width; must be <= WORD_SIZE.
- WAIT_CYCLES, 2, extra cycles per RAM access phase; used only with MEM_WAIT_STATE_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_indirect  in  1  1 = address is a pointer location (LDI/STI).
- req_address  in  ADDRESS_SIZE  access or pointer address.
- req_data  in  WORD_SIZE  store data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  WORD_SIZE  load result; holds last value otherwise.
- mem_read  out  1  to RAM read.
- mem_write  out  1  to RAM write.
- mem_address  out  ADDRESS_SIZE  to RAM address.
- mem_in_data  out  WORD_SIZE  to RAM in_data.
- mem_out_data  in  WORD_SIZE  from RAM out_data; valid the cycle after a read-strobe edge.

Behaviour:
- Reset, async, with reset_n low:
  - State goes to IDLE.
  - req_ready=1.
  - rsp_valid=0.
  - rsp_data=0.
  - mem_read=0.
  - mem_write=0.
  - mem_address=0.
  - mem_in_data=0.
  - Internal address, data and write/indirect registers are 0.
- Accept: at a clock edge where req_valid and req_ready are both 1, latch write, indirect, address and data. requests with req_valid=1 outside IDLE are ignored, not queued.
- States: IDLE, PTR_RD, PTR_CAP, DATA_RD, DATA_CAP, DATA_WR.
- Strobes are Moore outputs decoded from the state register. There is no combinational path from req_* to mem_*.
- mem_read=1 only in PTR_RD and DATA_RD. mem_write=1 only in DATA_WR. The two are never high together.
- mem_address is the latched address register in all states. mem_in_data is the latched store data.
- Transitions on accept, from IDLE:
  - indirect → PTR_RD.
  - else write → DATA_WR.
  - else → DATA_RD.
- Transitions on later edges:
  - PTR_RD → PTR_CAP.
  - PTR_CAP: the address register takes mem_out_data[ADDRESS_SIZE-1:0] (upper bits dropped); next state DATA_WR if write, else DATA_RD.
  - DATA_RD → DATA_CAP.
  - DATA_CAP: rsp_data takes mem_out_data, rsp_valid is set to 1, next state IDLE.
  - DATA_WR: the RAM writes at this edge; rsp_valid is set to 1, rsp_data is unchanged, next state IDLE.
- rsp_valid is exactly one cycle wide with no backpressure. A new request may be accepted at the edge ending that rsp_valid cycle.
- Latency, counted in edges from the accept edge to the edge that raises rsp_valid:
  - direct store: 1.
  - direct load: 2.
  - indirect store: 3.
  - indirect load: 4.
- Throughput: back-to-back direct loads complete one every 3 cycles.
- Pointer value 0xFFFF is legal: a full-range address with no wrap logic.
- Reset mid-operation aborts immediately: strobes drop and no response is issued. A write is performed only if reset_n is high at the DATA_WR edge.

Optional Feature:
- Macro: MEM_WAIT_STATE_EN.
- Defined:
  - PTR_RD, DATA_RD and DATA_WR each hold for WAIT_CYCLES+1 cycles, using a down-counter loaded on state entry; strobes and address stay stable throughout.
  - Capture happens only after the final strobe cycle.
  - Each latency above grows by WAIT_CYCLES per access phase. Example: a direct load becomes 2+WAIT_CYCLES edges.
  - WAIT_CYCLES=0 behaves identically to the undefined case.
- Undefined: no counter is built and WAIT_CYCLES is ignored.

Test Plan:
- Reset then idle: reset_n low for 2 cycles → all outputs at their reset values, req_ready=1; release → no strobes while req_valid=0.
- Direct load: RAM[0x0005]=0x1234, request load 0x0005 → mem_read high for exactly 1 cycle with mem_address=0x0005; rsp_valid 2 edges after accept with rsp_data=0x1234.
- Direct store then load: store 0xBEEF to 0x0003 → mem_write 1 cycle, rsp_valid 1 edge after accept; then load 0x0003 → rsp_data=0xBEEF.
- Indirect load: RAM[0x0005]=0x0000, RAM[0x0000]=0xF022, request LDI 0x0005 → two read strobes at addresses 0x0005 then 0x0000; rsp_data=0xF022 at 4 edges.
- Indirect store, plus busy-ignore: RAM[0x0006]=0x0003, STI 0x0006 data 0x00AA → RAM[0x0003]=0x00AA, rsp at 3 edges; a second req_valid pulse during the operation produces no extra strobes.
- Reset mid-indirect-store: assert reset_n low while in PTR_CAP → mem_write never asserted, RAM[target] unchanged, no rsp_valid; with MEM_WAIT_STATE_EN and WAIT_CYCLES=2, a direct load returns at 4 edges.
